// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: shares one fixed-latency memory port between the y86 core (port 0) and the loader (port 1).
// Define Y86_ARB_ROUND_ROBIN_EN to alternate the winner on contention instead of fixed port-0 priority.
module y86_mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic          gnt0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic          gnt1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_win;
   logic          r_we;
   logic          r_ack0, r_ack1, r_gnt0, r_gnt1;
   logic [DW-1:0] r_rdata0, r_rdata1;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_mem_re, r_mem_we;

   logic          w_pick1;
   logic          w_we_sel;
   logic [AW-1:0] w_addr_sel;
   logic [DW-1:0] w_wdata_sel;

`ifdef Y86_ARB_ROUND_ROBIN_EN
   logic          r_last;  // 1 = port 1 won the most recent transaction
`endif

   always_comb begin
      w_pick1 = 1'b0;
`ifdef Y86_ARB_ROUND_ROBIN_EN
      w_pick1 = req1 && (!req0 || !r_last);
`else
      w_pick1 = req1 && !req0;
`endif
      w_we_sel    = w_pick1 ? we1    : we0;
      w_addr_sel  = w_pick1 ? addr1  : addr0;
      w_wdata_sel = w_pick1 ? wdata1 : wdata0;
   end

   // mem_addr/mem_wdata double as the command latch, so they are loaded on the IDLE grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_win       <= 1'b0;
         r_we        <= 1'b0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
`ifdef Y86_ARB_ROUND_ROBIN_EN
         r_last      <= 1'b1;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req0 || req1) begin
                  r_win       <= w_pick1;
                  r_we        <= w_we_sel;
                  r_gnt0      <= !w_pick1;
                  r_gnt1      <= w_pick1;
                  r_mem_addr  <= w_addr_sel;
                  r_mem_wdata <= w_wdata_sel;
                  r_mem_re    <= !w_we_sel;
                  r_mem_we    <= w_we_sel;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_mem_re <= 1'b0;
               r_mem_we <= 1'b0;
               r_cnt    <= LAT_LOAD;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  if (!r_we) begin
                     if (r_win) r_rdata1 <= mem_rdata;
                     else       r_rdata0 <= mem_rdata;
                  end
                  r_ack0  <= !r_win;
                  r_ack1  <= r_win;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_gnt0  <= 1'b0;
               r_gnt1  <= 1'b0;
`ifdef Y86_ARB_ROUND_ROBIN_EN
               r_last  <= r_win;
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ack0      = r_ack0;
   assign ack1      = r_ack1;
   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign rdata0    = r_rdata0;
   assign rdata1    = r_rdata1;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_re    = r_mem_re;
   assign mem_we    = r_mem_we;

endmodule
